// File: rtl/dtw_pkg.sv
// Shared DTW definitions: index width, traceback path encodings and the
// traceback controller state encoding.
package dtw_pkg;

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] IDX_INVALID = 5'd31;

  localparam logic [1:0] PATH_DIAG = 2'b11;
  localparam logic [1:0] PATH_UP   = 2'b10;
  localparam logic [1:0] PATH_LEFT = 2'b01;
  localparam logic [1:0] PATH_RST  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } tb_state_t;

endpackage

// File: rtl/dtw_traceback_ctrl_cell_sel.sv
// Combinational cell selector: (cur_t,cur_r) -> one-hot unit enable, plus the
// selected unit's {diag, up, left} strobes.
module dtw_traceback_ctrl_cell_sel
  import dtw_pkg::*;
#(
  parameter int N_T = 8,
  parameter int N_R = 8
) (
  input  logic [IDX_W-1:0]   cur_t,
  input  logic [IDX_W-1:0]   cur_r,
  input  logic [N_T*N_R-1:0] ena0_v,
  input  logic [N_T*N_R-1:0] ena1_v,
  input  logic [N_T*N_R-1:0] ena2_v,
  output logic [N_T*N_R-1:0] onehot,
  output logic [2:0]         strobes
);

  always_comb begin
    onehot = '0;
    for (int t = 0; t < N_T; t++) begin
      for (int r = 0; r < N_R; r++) begin
        if (cur_t == IDX_W'(t) && cur_r == IDX_W'(r)) onehot[t*N_R+r] = 1'b1;
      end
    end
  end

  // Masking with the decode avoids a variable-index mux per strobe vector.
  assign strobes = {|(ena0_v & onehot), |(ena1_v & onehot), |(ena2_v & onehot)};

endmodule

// File: rtl/dtw_traceback_ctrl.sv
// DTW traceback sequencer: walks the score-unit array from (t_len-1,r_len-1)
// to (0,0), copying each unit's bus word to SRAM and following its strobes.
module dtw_traceback_ctrl
  import dtw_pkg::*;
#(
  parameter int N_T       = 8,
  parameter int N_R       = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [IDX_W-1:0]   t_len,
  input  logic [IDX_W-1:0]   r_len,
  output logic [N_T*N_R-1:0] outena,
  input  logic [31:0]        bus_data,
  input  logic [N_T*N_R-1:0] ena0_v,
  input  logic [N_T*N_R-1:0] ena1_v,
  input  logic [N_T*N_R-1:0] ena2_v,
  input  logic               sram_gnt,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [5:0]         path_len,
  output logic [IDX_W-1:0]   cur_t,
  output logic [IDX_W-1:0]   cur_r
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  tb_state_t         state, state_nxt;
  logic [IDX_W-1:0]  cur_t_nxt, cur_r_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [5:0]        path_len_nxt;
  logic              err_nxt;
  logic [N_T*N_R-1:0] onehot;
  logic [2:0]        strobes;
  logic              bad_cfg;
  logic              at_origin;

  dtw_traceback_ctrl_cell_sel #(
    .N_T (N_T),
    .N_R (N_R)
  ) u_cell_sel (
    .cur_t   (cur_t),
    .cur_r   (cur_r),
    .ena0_v  (ena0_v),
    .ena1_v  (ena1_v),
    .ena2_v  (ena2_v),
    .onehot  (onehot),
    .strobes (strobes)
  );

  assign bad_cfg   = (t_len == '0) || (r_len == '0) ||
                     (int'(t_len) > N_T) || (int'(r_len) > N_R);
  assign at_origin = (cur_t == '0) && (cur_r == '0);

  // Decoded from the async-reset state, so outena drops the moment nrst falls.
  assign outena     = (state == EMIT) ? onehot : '0;
  assign sram_we    = (state == EMIT) && sram_gnt;
  assign sram_wdata = bus_data;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cur_t     <= '0;
      cur_r     <= '0;
      sram_addr <= BASE;
      path_len  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_t     <= cur_t_nxt;
      cur_r     <= cur_r_nxt;
      sram_addr <= addr_nxt;
      path_len  <= path_len_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cur_t_nxt    = cur_t;
    cur_r_nxt    = cur_r;
    addr_nxt     = sram_addr;
    path_len_nxt = path_len;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt      = 1'b0;
          path_len_nxt = '0;
          addr_nxt     = BASE;
          if (bad_cfg) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            cur_t_nxt = t_len - 1'b1;
            cur_r_nxt = r_len - 1'b1;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (sram_gnt) begin
          addr_nxt     = sram_addr + 1'b1;
          path_len_nxt = path_len + 1'b1;
          state_nxt    = at_origin ? DONE : WAIT;
        end
      end
      WAIT: begin
        // Any strobe pattern not matched below is a broken or illegal path.
        state_nxt = DONE;
        err_nxt   = 1'b1;
        case (strobes)
          3'b100: if (cur_t != '0 && cur_r != '0) begin
            cur_t_nxt = cur_t - 1'b1;
            cur_r_nxt = cur_r - 1'b1;
            state_nxt = EMIT;
            err_nxt   = err;
          end
          3'b010: if (cur_t != '0) begin
            cur_t_nxt = cur_t - 1'b1;
            state_nxt = EMIT;
            err_nxt   = err;
          end
          3'b001: if (cur_r != '0) begin
            cur_r_nxt = cur_r - 1'b1;
            state_nxt = EMIT;
            err_nxt   = err;
          end
          default: ;
        endcase
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtw_traceback_ctrl.sv
// Scenario bench for dtw_traceback_ctrl: a model unit array drives the bus
// and strobes from a direction table; SRAM writes are checked off a queue.
module tb_dtw_traceback_ctrl;
  import dtw_pkg::*;

  localparam int NT = 8;
  localparam int NR = 8;
  localparam int NC = NT * NR;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    t_len = '0;
  logic [4:0]    r_len = '0;
  logic [NC-1:0] outena;
  logic [31:0]   bus_data;
  logic [NC-1:0] ena0_v, ena1_v, ena2_v;
  logic          sram_gnt = 1'b1;
  logic          sram_we;
  logic [7:0]    sram_addr;
  logic [31:0]   sram_wdata;
  logic          busy, done, err;
  logic [5:0]    path_len;
  logic [4:0]    cur_t, cur_r;

  logic [1:0] dir [NT][NR];

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];

  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;

  dtw_traceback_ctrl #(.N_T(NT), .N_R(NR), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .nrst(nrst), .start(start), .t_len(t_len), .r_len(r_len),
    .outena(outena), .bus_data(bus_data),
    .ena0_v(ena0_v), .ena1_v(ena1_v), .ena2_v(ena2_v),
    .sram_gnt(sram_gnt), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .busy(busy), .done(done), .err(err),
    .path_len(path_len), .cur_t(cur_t), .cur_r(cur_r)
  );

  always #5 clk = ~clk;

  // Model unit array: the enabled unit drives a tag of its own index.
  always_comb begin
    bus_data = 32'hDEAD_BEEF;
    for (int i = 0; i < NC; i++) if (outena[i]) bus_data = 32'hC0DE_0000 | 32'(i);
  end

  always_comb begin
    ena0_v = '0; ena1_v = '0; ena2_v = '0;
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < NR; r++) begin
        ena0_v[t*NR+r] = (dir[t][r] == PATH_DIAG);
        ena1_v[t*NR+r] = (dir[t][r] == PATH_UP);
        ena2_v[t*NR+r] = (dir[t][r] == PATH_LEFT);
      end
    end
  end

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (nrst && sram_we) begin
      wr_t got, want;
      n_writes++;
      n_checks++;
      got = {sram_addr, sram_wdata};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sram_write unexpected: got addr=%0d data=%h, required no write", sram_addr, sram_wdata);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL sram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   got.addr, got.data, want.addr, want.data);
        end
      end
    end
  end

  task automatic exp_write(input int addr, input int t, input int r);
    wr_t w;
    w.addr = 8'(addr);
    w.data = 32'hC0DE_0000 | 32'(t * NR + r);
    q.push_back(w);
  endtask

  task automatic fill_dir(input logic [1:0] d);
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) dir[t][r] = d;
  endtask

  // Start pulse occupies cycle 0; returns at +1 after the edge opening cycle 1.
  task automatic do_start(input int t, input int r);
    @(posedge clk); #1;
    start = 1'b1; t_len = 5'(t); r_len = 5'(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle index of done (or -1), positioned at that cycle's negedge.
  task automatic wait_done(input int k0, input int budget, output int dc);
    dc = -1;
    for (int k = k0; k <= budget; k++) begin
      @(negedge clk);
      if (done) begin
        dc = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    n_checks++; if (outena !== '0)   begin n_fail++; $display("FAIL reset_outena: got %h, required 0", outena); end
    n_checks++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", sram_we); end
    n_checks++; if (sram_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", sram_addr); end
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/err=%b, required 000", {busy, done, err}); end
    n_checks++; if ({path_len, cur_t, cur_r} !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got len=%0d t=%0d r=%0d, required 0", path_len, cur_t, cur_r); end
  endtask

  task automatic test_diagonal();
    int dc, w0;
    fill_dir(PATH_DIAG);
    sram_gnt = 1'b1;
    exp_write(0, 2, 2); exp_write(1, 1, 1); exp_write(2, 0, 0);
    w0 = n_writes;
    do_start(3, 3);
    wait_done(1, 40, dc);
    n_checks++; if (dc !== 6) begin n_fail++; $display("FAIL diag_done_cycle: got %0d, required 6", dc); end
    n_checks++; if (path_len !== 6'd3) begin n_fail++; $display("FAIL diag_path_len: got %0d, required 3", path_len); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL diag_err: got %b, required 0", err); end
    n_checks++; if (n_writes - w0 !== 3 || q.size() != 0) begin n_fail++; $display("FAIL diag_writes: got %0d left %0d, required 3 left 0", n_writes - w0, q.size()); end
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL diag_idle: got busy/done=%b, required 00", {busy, done}); end
  endtask

  task automatic test_mixed();
    int dc, w0;
    fill_dir(PATH_RST);
    dir[3][1] = PATH_UP; dir[2][1] = PATH_DIAG; dir[1][0] = PATH_UP;
    exp_write(0, 3, 1); exp_write(1, 2, 1); exp_write(2, 1, 0); exp_write(3, 0, 0);
    w0 = n_writes;
    do_start(4, 2);
    wait_done(1, 40, dc);
    n_checks++; if (dc !== 8) begin n_fail++; $display("FAIL mixed_done_cycle: got %0d, required 8", dc); end
    n_checks++; if (path_len !== 6'd4) begin n_fail++; $display("FAIL mixed_path_len: got %0d, required 4", path_len); end
    n_checks++; if (n_writes - w0 !== 4 || q.size() != 0 || err !== 1'b0) begin n_fail++; $display("FAIL mixed_writes: got %0d err=%b, required 4 err=0", n_writes - w0, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int dc, w0;
    fill_dir(PATH_DIAG);
    exp_write(0, 1, 1); exp_write(1, 0, 0);
    w0 = n_writes;
    sram_gnt = 1'b0;
    do_start(2, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if (outena !== (64'd1 << (1 * NR + 1)) || sram_we !== 1'b0) begin n_fail++; $display("FAIL stall_hold c%0d: got outena=%h we=%b, required bit 9 we=0", c, outena, sram_we); end
      @(posedge clk); #1;
    end
    sram_gnt = 1'b1;
    wait_done(4, 40, dc);
    n_checks++; if (dc !== 7) begin n_fail++; $display("FAIL stall_done_cycle: got %0d, required 7", dc); end
    n_checks++; if (n_writes - w0 !== 2 || q.size() != 0) begin n_fail++; $display("FAIL stall_writes: got %0d, required 2", n_writes - w0); end
    @(posedge clk); #1;
  endtask

  task automatic test_broken();
    int dc, w0;
    fill_dir(PATH_DIAG);
    dir[1][1] = PATH_RST;
    exp_write(0, 1, 1);
    w0 = n_writes;
    do_start(2, 2);
    wait_done(1, 40, dc);
    n_checks++; if (dc !== 3 || err !== 1'b1) begin n_fail++; $display("FAIL broken_done: got cycle %0d err=%b, required 3 err=1", dc, err); end
    n_checks++; if (path_len !== 6'd1 || n_writes - w0 !== 1) begin n_fail++; $display("FAIL broken_len: got %0d writes %0d, required 1 and 1", path_len, n_writes - w0); end
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if (outena !== '0 || done !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL broken_after: got outena=%h done=%b err=%b, required 0 0 1", outena, done, err); end
    // Two strobes at once is also a broken path.
    fill_dir(PATH_DIAG);
    dir[1][1] = PATH_DIAG;
    exp_write(0, 1, 1);
    force ena1_v[1 * NR + 1] = 1'b1;
    do_start(2, 2);
    wait_done(1, 40, dc);
    release ena1_v[1 * NR + 1];
    n_checks++; if (dc !== 3 || err !== 1'b1 || path_len !== 6'd1) begin n_fail++; $display("FAIL multi_strobe: got cycle %0d err=%b len=%0d, required 3 1 1", dc, err, path_len); end
    @(posedge clk); #1;
    // Left strobe at column 0 would underflow.
    fill_dir(PATH_LEFT);
    exp_write(0, 1, 0);
    do_start(2, 1);
    wait_done(1, 40, dc);
    n_checks++; if (dc !== 3 || err !== 1'b1) begin n_fail++; $display("FAIL underflow: got cycle %0d err=%b, required 3 1", dc, err); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_cfg();
    int dc, w0;
    w0 = n_writes;
    do_start(0, 3);
    wait_done(1, 20, dc);
    n_checks++; if (dc < 1 || dc > 2 || err !== 1'b1) begin n_fail++; $display("FAIL bad_t0: got cycle %0d err=%b, required 1..2 err=1", dc, err); end
    @(posedge clk); #1;
    do_start(2, NR + 1);
    wait_done(1, 20, dc);
    n_checks++; if (dc < 1 || dc > 2 || err !== 1'b1 || path_len !== 6'd0) begin n_fail++; $display("FAIL bad_r: got cycle %0d err=%b len=%0d, required 1..2 1 0", dc, err, path_len); end
    n_checks++; if (n_writes - w0 !== 0) begin n_fail++; $display("FAIL bad_no_write: got %0d, required 0", n_writes - w0); end
    @(posedge clk); #1;
    fill_dir(PATH_RST);
    exp_write(0, 0, 0);
    do_start(1, 1);
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, required 0", err); end
    @(posedge clk); #1;
    wait_done(2, 20, dc);
    n_checks++; if (dc !== 2 || err !== 1'b0 || path_len !== 6'd1) begin n_fail++; $display("FAIL one_cell: got cycle %0d err=%b len=%0d, required 2 0 1", dc, err, path_len); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int dc, w0;
    fill_dir(PATH_DIAG);
    exp_write(0, 1, 1); exp_write(1, 0, 0);
    w0 = n_writes;
    do_start(2, 2);
    start = 1'b1; t_len = 5'd5; r_len = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, 40, dc);
    n_checks++; if (dc !== 4 || path_len !== 6'd2 || n_writes - w0 !== 2) begin n_fail++; $display("FAIL ignore_start: got cycle %0d len=%0d writes=%0d, required 4 2 2", dc, path_len, n_writes - w0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dc;
    fill_dir(PATH_DIAG);
    sram_gnt = 1'b0;
    do_start(3, 3);
    @(negedge clk);
    n_checks++; if (outena === '0) begin n_fail++; $display("FAIL mid_pre: got outena=0, required cell (2,2) enabled"); end
    nrst = 1'b0;
    #1;
    n_checks++; if (outena !== '0 || sram_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bus: got outena=%h we=%b, required 0 0", outena, sram_we); end
    n_checks++; if ({busy, done, err} !== 3'b000 || sram_addr !== 8'd0 || {path_len, cur_t, cur_r} !== 16'd0) begin n_fail++; $display("FAIL mid_reset_state: got flags=%b addr=%0d len=%0d t=%0d r=%0d, required all 0", {busy, done, err}, sram_addr, path_len, cur_t, cur_r); end
    #2 nrst = 1'b1;
    q.delete();
    sram_gnt = 1'b1;
    exp_write(0, 1, 1); exp_write(1, 0, 0);
    do_start(2, 2);
    wait_done(1, 40, dc);
    n_checks++; if (dc !== 4 || path_len !== 6'd2 || err !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL mid_rerun: got cycle %0d len=%0d err=%b, required 4 2 0", dc, path_len, err); end
    @(posedge clk); #1;
  endtask

  initial begin
    fill_dir(PATH_RST);
    test_reset();
    test_diagonal();
    test_mixed();
    test_stall();
    test_broken();
    test_bad_cfg();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
